// File: rtl/neuron_accum_seq.sv
// Bias-plus-products accumulator for one MLP neuron.
// One shared ripple adder, saturating result, valid/ready on both sides.
module ripple_adder #(
  parameter int BITS = 24
) (
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  input  logic            cin,
  output logic [BITS-1:0] sum,
  output logic            cout
);

  for (genvar i = 0; i < BITS; i++) begin : g_bit
    logic ci;
    logic co;
    if (i == 0) begin : g_lsb
      assign ci = cin;
    end else begin : g_mid
      assign ci = g_bit[i-1].co;
    end
    assign sum[i] = a[i] ^ b[i] ^ ci;
    assign co = (a[i] & b[i]) | (ci & (a[i] ^ b[i]));
  end

  assign cout = g_bit[BITS-1].co;

endmodule

module neuron_accum_seq #(
  parameter int DATA_BITS  = 16,
  parameter int ACC_BITS   = 24,
  parameter int NUM_INPUTS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] bias,
  output logic                 busy,
  input  logic                 in_valid,
  input  logic [DATA_BITS-1:0] in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [ACC_BITS-1:0]  out_data,
  output logic                 out_sat,
  input  logic                 out_ready
);

  localparam int CNT_BITS = $clog2(NUM_INPUTS + 1);
  localparam int MSB = ACC_BITS - 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [ACC_BITS-1:0] acc_q;
  logic [CNT_BITS-1:0] cnt_q;
  logic                sat_q;

  logic [ACC_BITS-1:0] bias_ext;
  logic [ACC_BITS-1:0] in_ext;
  logic [ACC_BITS-1:0] sum;
  logic [ACC_BITS-1:0] sat_val;
  logic                unused_cout;
  logic                ovf;
  logic                accept;
  logic                last;

  assign bias_ext = ACC_BITS'($signed(bias));
  assign in_ext   = ACC_BITS'($signed(in_data));

  ripple_adder #(
    .BITS(ACC_BITS)
  ) u_add (
    .a   (acc_q),
    .b   (in_ext),
    .cin (1'b0),
    .sum (sum),
    .cout(unused_cout)
  );

  // Same-sign operands with a flipped result sign means overflow.
  assign ovf = (acc_q[MSB] == in_ext[MSB]) && (sum[MSB] != acc_q[MSB]);
  assign sat_val = acc_q[MSB] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};

  assign accept = in_valid && (state_q == ACCUM);
  assign last   = (cnt_q == CNT_BITS'(NUM_INPUTS - 1));

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = ACCUM;
      end
      ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && last) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        acc_q <= bias_ext;
        cnt_q <= '0;
        sat_q <= 1'b0;
      end else if (accept) begin
        acc_q <= ovf ? sat_val : sum;
        cnt_q <= cnt_q + CNT_BITS'(1);
        if (ovf) sat_q <= 1'b1;
      end
    end
  end

  assign out_data = out_valid ? acc_q : '0;
  assign out_sat  = out_valid & sat_q;

endmodule

// File: tb/tb_neuron_accum_seq.sv
// Directed bench: two lockstep instances (24-bit and 17-bit accumulators)
// sharing one stimulus stream, NUM_INPUTS=4.
module tb_neuron_accum_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] bias;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_ready;

  logic        busy_a, in_ready_a, out_valid_a, out_sat_a;
  logic [23:0] out_data_a;
  logic        busy_b, in_ready_b, out_valid_b, out_sat_b;
  logic [16:0] out_data_b;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int t_done0;

  always #5 clk = ~clk;

  neuron_accum_seq #(
    .DATA_BITS(16), .ACC_BITS(24), .NUM_INPUTS(4)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .bias(bias),
    .busy(busy_a), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_a), .out_valid(out_valid_a),
    .out_data(out_data_a), .out_sat(out_sat_a),
    .out_ready(out_ready)
  );

  neuron_accum_seq #(
    .DATA_BITS(16), .ACC_BITS(17), .NUM_INPUTS(4)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .bias(bias),
    .busy(busy_b), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_b), .out_valid(out_valid_b),
    .out_data(out_data_b), .out_sat(out_sat_b),
    .out_ready(out_ready)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic int sa(input logic [23:0] v);
    return int'($signed(v));
  endfunction

  function automatic int sb(input logic [16:0] v);
    return int'($signed(v));
  endfunction

  // Start a neuron and stream four products on consecutive cycles.
  task automatic run4(input int b, input int d0, input int d1,
                      input int d2, input int d3);
    int d[4];
    d = '{d0, d1, d2, d3};
    start = 1'b1;
    bias  = 16'(b);
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(d[i]);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic take();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; bias = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step();
    step();
    chk("rst busy", int'(busy_a), 0);
    chk("rst in_ready", int'(in_ready_a), 0);
    chk("rst out_valid", int'(out_valid_a), 0);
    chk("rst out_data", sa(out_data_a), 0);
    chk("rst out_sat", int'(out_sat_b), 0);
    rst_n = 1'b1;
    step();

    // basic sum, with latency and busy checks
    start = 1'b1; bias = 16'd10;
    step();
    start = 1'b0;
    chk("t1 busy", int'(busy_a), 1);
    chk("t1 in_ready", int'(in_ready_a), 1);
    for (int i = 1; i <= 4; i++) begin
      chk("t1 no valid yet", int'(out_valid_a), 0);
      in_valid = 1'b1; in_data = 16'(i);
      step();
    end
    in_valid = 1'b0;
    chk("t1 out_valid", int'(out_valid_a), 1);
    chk("t1 in_ready done", int'(in_ready_a), 0);
    chk("t1 sum a", sa(out_data_a), 20);
    chk("t1 sum b", sb(out_data_b), 20);
    chk("t1 sat", int'(out_sat_a), 0);
    take();
    chk("t1 valid drop", int'(out_valid_a), 0);
    chk("t1 busy drop", int'(busy_a), 0);

    // signed accumulation
    run4(-5, -1, -2, 3, -4);
    chk("t2 sum a", sa(out_data_a), -9);
    chk("t2 raw a", int'(out_data_a), 24'hFFFFF7);
    chk("t2 sum b", sb(out_data_b), -9);
    chk("t2 sat", int'(out_sat_b), 0);
    take();

    // positive saturation on the 17-bit instance only
    run4(32767, 32767, 32767, 32767, 32767);
    chk("t3 pos a", sa(out_data_a), 163835);
    chk("t3 pos a sat", int'(out_sat_a), 0);
    chk("t3 pos b", sb(out_data_b), 65535);
    chk("t3 pos b sat", int'(out_sat_b), 1);
    take();
    run4(-32768, -32768, -32768, -32768, -32768);
    chk("t3 neg a", sa(out_data_a), -163840);
    chk("t3 neg b", sb(out_data_b), -65536);
    chk("t3 neg b sat", int'(out_sat_b), 1);
    take();

    // input bubbles: valid 1,0,0,1,1,0,1
    start = 1'b1; bias = 16'd0;
    step();
    start = 1'b0;
    begin
      int vld[7];
      int dat[7];
      vld = '{1, 0, 0, 1, 1, 0, 1};
      dat = '{7, 99, 99, 8, 9, 99, 10};
      for (int i = 0; i < 7; i++) begin
        if (i == 6) chk("t4 pending", int'(out_valid_a), 0);
        in_valid = vld[i][0];
        in_data  = 16'(dat[i]);
        step();
      end
    end
    in_valid = 1'b0;
    chk("t4 valid", int'(out_valid_a), 1);
    chk("t4 sum", sa(out_data_a), 34);

    // hold in DONE with start pulsing
    for (int i = 0; i < 5; i++) begin
      start = i[0] ? 1'b0 : 1'b1;
      bias  = 16'd500;
      step();
      chk("t4 hold valid", int'(out_valid_a), 1);
      chk("t4 hold data", sa(out_data_b), 34);
      chk("t4 hold in_ready", int'(in_ready_a), 0);
    end
    start = 1'b0;
    take();
    chk("t4 released", int'(out_valid_a), 0);

    // reset after two accepts of a saturating run
    start = 1'b1; bias = 16'd32767;
    step();
    start = 1'b0;
    in_valid = 1'b1; in_data = 16'd32767;
    step();
    step();
    in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    chk("t5 busy", int'(busy_b), 0);
    chk("t5 in_ready", int'(in_ready_b), 0);
    chk("t5 out_valid", int'(out_valid_b), 0);
    chk("t5 out_data", sb(out_data_b), 0);
    chk("t5 out_sat", int'(out_sat_b), 0);
    rst_n = 1'b1;
    step();
    run4(0, 5, 5, 5, 5);
    chk("t5 sum", sa(out_data_a), 20);
    chk("t5 sum b", sb(out_data_b), 20);
    chk("t5 sat b", int'(out_sat_b), 0);
    take();

    // back-to-back: saturating neuron then clean neuron
    run4(32767, 32767, 32767, 32767, 32767);
    chk("t6 first sat", int'(out_sat_b), 1);
    t_done0 = cyc;
    take();
    run4(1, 1, 1, 1, 1);
    chk("t6 second valid", int'(out_valid_b), 1);
    chk("t6 second sum", sb(out_data_b), 5);
    chk("t6 sat cleared", int'(out_sat_b), 0);
    chk("t6 period", cyc - t_done0, 6);
    take();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/neuron_accum_seq.md
Name: neuron_accum_seq

Overview:
Sequencer that drives one shared signed ripple adder instance (parameter bits = ACC_BITS, Cin tied 0) to accumulate the weighted-input products of one MLP neuron, starting from a bias term. Products arrive over a valid/ready stream from the multiplier stage. The block saturates on overflow and presents the neuron sum to the activation stage over a second valid/ready handshake.

Parameters:
DATA_BITS, 16, width of signed bias and product inputs
ACC_BITS, 24, width of signed accumulator/result; must be >= DATA_BITS
NUM_INPUTS, 16, products accumulated per neuron; >= 1

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  begin a neuron; sampled only in IDLE
bias  input  DATA_BITS  signed bias, captured when start is accepted
busy  output  1  high in ACCUM and DONE
in_valid  input  1  product valid
in_data  input  DATA_BITS  signed product
in_ready  output  1  block accepts a product this cycle
out_valid  output  1  result valid
out_data  output  ACC_BITS  signed saturated neuron sum
out_sat  output  1  saturation occurred at least once during this neuron
out_ready  input  1  downstream accepts result

Behaviour:
- Reset: rst_n low at a clk edge sends state to IDLE and clears acc, cnt, sat flag, and all outputs (busy, in_ready, out_valid, out_data, out_sat = 0). Applies from any state; a partial sum is discarded.
- FSM states: IDLE, ACCUM, DONE. in_ready, busy and out_valid decode combinationally from state.
- IDLE: in_ready=0, out_valid=0, busy=0. On start=1: acc <= sign-extended bias, cnt <= 0, sat <= 0, next state ACCUM.
- ACCUM: in_ready=1, busy=1. Accept occurs when in_valid && in_ready.
  - On accept: acc <= sat_add(acc, sign-extended in_data), cnt <= cnt+1.
  - On the accept where cnt == NUM_INPUTS-1: next state DONE.
  - When in_valid=0: no change (bubbles allowed, no timeout). start is ignored.
- DONE: out_valid=1, in_ready=0, busy=1. out_data=acc and out_sat=sat, held stable until out_ready=1.
  - On out_ready: next state IDLE; out_valid is low the following cycle. start is ignored in DONE, even in the same cycle as out_ready.
- Latency: out_valid rises the cycle after the final accept. Minimum period per neuron is NUM_INPUTS+2 cycles (start, N accepts, one DONE cycle with out_ready=1).
- Arithmetic:
  - Operands are sign-extended to ACC_BITS and summed through the single adder instance. No other adder is used for the datapath.
  - cnt is a separate incrementer of width clog2(NUM_INPUTS+1).
  - Overflow is detected when the operand signs are equal and the Sum sign differs. On positive overflow acc clamps to 2^(ACC_BITS-1)-1; on negative overflow it clamps to -2^(ACC_BITS-1). sat becomes 1 and stays set (sticky) until the next start.
  - Accumulation continues from the clamped value. Adder Cout is not used for overflow detection.
- NUM_INPUTS=1: a single accept goes straight to DONE.

Test Plan:
1. NUM_INPUTS=4. Apply bias=10, then inputs 1,2,3,4 on consecutive cycles -> out_valid one cycle after the 4th accept; out_data=20, out_sat=0; busy high from the cycle after start until out_ready is taken.
2. Signed accumulation: bias=-5, inputs -1,-2,3,-4 -> out_data=-9 (all ones in the upper bits), out_sat=0.
3. Saturation with ACC_BITS=17, DATA_BITS=16, NUM_INPUTS=4:
   - bias=32767, four inputs of 32767 -> out_data=65535, out_sat=1.
   - bias=-32768, four inputs of -32768 -> out_data=-65536, out_sat=1.
4. Handshake stalls:
   - in_valid pattern 1,0,0,1,1,0,1 -> exactly 4 accepts counted, correct sum.
   - Hold out_ready=0 for 5 cycles in DONE with start pulsed -> out_data stable, in_ready=0, start ignored, state remains DONE.
5. Reset mid-operation: drop rst_n after 2 accepts -> all outputs 0 on the next edge. A subsequent run with bias=0 and inputs 5,5,5,5 produces 20 with no residue from the aborted run.
6. Back-to-back neurons: assert out_ready in DONE, then start on the first IDLE cycle -> second result correct, out_sat cleared, and the period per neuron is NUM_INPUTS+2 cycles.
